// File: rtl/edge_cache_ctrl.sv
// edge_cache_ctrl: shares the single-port edge cache RAM between loader writes and relax-stage
// queries with round-robin arbitration, and sweeps the whole RAM to +infinity on request.
module edge_cache_ctrl #(
    parameter int MAX_NODES = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int VALUE_WIDTH = 32,
    parameter logic [VALUE_WIDTH-1:0] INF_VALUE = 32'h7F800000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_start,
    output logic                     busy,
    output logic                     clear_done,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [INDEX_WIDTH-1:0]   w_from,
    input  logic [INDEX_WIDTH-1:0]   w_to,
    input  logic [VALUE_WIDTH-1:0]   w_data,
    input  logic                     q_valid,
    output logic                     q_ready,
    input  logic [INDEX_WIDTH-1:0]   q_from,
    input  logic [INDEX_WIDTH-1:0]   q_to,
    output logic                     q_resp_valid,
    output logic [VALUE_WIDTH-1:0]   q_resp_data,
    output logic [2*INDEX_WIDTH-1:0] mem_address,
    output logic                     mem_write_enable,
    output logic [VALUE_WIDTH-1:0]   mem_write_data,
    input  logic [VALUE_WIDTH-1:0]   mem_edge_value
);
    localparam logic [INDEX_WIDTH:0] NODES = (INDEX_WIDTH+1)'(MAX_NODES);
    localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(MAX_NODES - 1);

    typedef enum logic {SERVE, CLEAR} state_t;

    state_t state_q, state_d;
    logic ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0] from_q, from_d, to_q, to_d;
    logic [2*INDEX_WIDTH-1:0] addr_q, addr_d;
    logic we_q, we_d;
    logic [VALUE_WIDTH-1:0] wdata_q, wdata_d;
    logic done_q, done_d;
    logic qv1_q, qv1_d, qoor1_q, qoor1_d, qv2_q, qv2_d, qoor2_q, qoor2_d;
    logic open, w_fire, q_fire, w_oor, q_oor, wrap, sweep_end;

    // ptr_q high means the query port won the last transfer, so a tie goes to the writer
    assign open = state_q == SERVE && !clear_start && !reset;
    assign w_ready = open && (!q_valid || ptr_q);
    assign q_ready = open && (!w_valid || !ptr_q);
    assign w_fire = w_valid && w_ready;
    assign q_fire = q_valid && q_ready;
    assign w_oor = {1'b0, w_from} >= NODES || {1'b0, w_to} >= NODES;
    assign q_oor = {1'b0, q_from} >= NODES || {1'b0, q_to} >= NODES;
    assign wrap = from_q == LAST;
    assign sweep_end = wrap && to_q == LAST;

    assign busy = state_q == CLEAR;
    assign clear_done = done_q;
    assign mem_address = addr_q;
    assign mem_write_enable = we_q;
    assign mem_write_data = wdata_q;
    assign q_resp_valid = qv2_q;
    assign q_resp_data = qv2_q ? (qoor2_q ? INF_VALUE : mem_edge_value) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        from_d = from_q;
        to_d = to_q;
        addr_d = addr_q;
        we_d = 1'b0;
        wdata_d = wdata_q;
        done_d = 1'b0;
        qv1_d = q_fire;
        qoor1_d = q_fire && q_oor;
        qv2_d = qv1_q;
        qoor2_d = qoor1_q;
        if (state_q == SERVE) begin
            if (clear_start) begin
                // the first sweep write goes out on the same edge that enters CLEAR
                state_d = CLEAR;
                from_d = '0;
                to_d = '0;
                addr_d = '0;
                we_d = 1'b1;
                wdata_d = INF_VALUE;
                done_d = MAX_NODES == 1;
            end else if (w_fire) begin
                ptr_d = 1'b0;
                addr_d = {w_to, w_from};
                wdata_d = w_data;
                we_d = !w_oor;
            end else if (q_fire) begin
                ptr_d = 1'b1;
                addr_d = {q_to, q_from};
            end
        end else if (sweep_end) begin
            state_d = SERVE;
        end else begin
            from_d = wrap ? '0 : from_q + 1'b1;
            to_d = wrap ? to_q + 1'b1 : to_q;
            addr_d = {to_d, from_d};
            we_d = 1'b1;
            wdata_d = INF_VALUE;
            done_d = from_d == LAST && to_d == LAST;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SERVE;
            ptr_q <= 1'b1;
            from_q <= '0;
            to_q <= '0;
            addr_q <= '0;
            we_q <= 1'b0;
            wdata_q <= '0;
            done_q <= 1'b0;
            qv1_q <= 1'b0;
            qoor1_q <= 1'b0;
            qv2_q <= 1'b0;
            qoor2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            from_q <= from_d;
            to_q <= to_d;
            addr_q <= addr_d;
            we_q <= we_d;
            wdata_q <= wdata_d;
            done_q <= done_d;
            qv1_q <= qv1_d;
            qoor1_q <= qoor1_d;
            qv2_q <= qv2_d;
            qoor2_q <= qoor2_d;
        end
    end
endmodule

// File: doc/edge_cache_ctrl.md
# edge_cache_ctrl

Sequencer and arbiter for the Dijkstra edge cache RAM (`EdgeCacheMem`). It shares the single-port RAM between two requesters: a loader write port, used while streaming the graph in, and a query read port, used by the relax stage to fetch edge weights. It also runs a bulk clear that fills every entry with +infinity. It sits between the graph loader / relax unit and the RAM, and owns all RAM address, write-enable and write-data drive.

## Interface
- MAX_NODES, 32, number of graph nodes; valid indices 0..MAX_NODES-1
- INDEX_WIDTH, 5, width of one node index; RAM address is 2*INDEX_WIDTH
- VALUE_WIDTH, 32, edge weight width (IEEE-754 single)
- INF_VALUE, 32'h7F800000, value written by clear and returned for out-of-range queries
---
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clear_start  in  1  one-cycle pulse; start bulk clear
- busy  out  1  high while in CLEAR
- clear_done  out  1  one-cycle pulse on the last clear write
- w_valid / w_ready  in / out  1  loader handshake
- w_from, w_to  in  INDEX_WIDTH  edge endpoints
- w_data  in  VALUE_WIDTH  edge weight
- q_valid / q_ready  in / out  1  query handshake
- q_from, q_to  in  INDEX_WIDTH  edge endpoints
- q_resp_valid  out  1  one-cycle response strobe
- q_resp_data  out  VALUE_WIDTH  edge weight
- mem_address  out  2*INDEX_WIDTH  RAM address = {to, from}; registered
- mem_write_enable  out  1  RAM write strobe; registered
- mem_write_data  out  VALUE_WIDTH  RAM write data; registered
- mem_edge_value  in  VALUE_WIDTH  RAM registered read data

## Operation
- Two states: SERVE and CLEAR. Reset enters SERVE.
- Reset values:
  - all outputs 0, except q_resp_data = 0 and mem_address = 0
  - round-robin pointer = "query last" (the first tie goes to the write port)
  - RAM contents are undefined until a clear has run
- **SERVE arbitration.** At most one transfer per cycle.
  - w_ready = SERVE & !clear_start & (!q_valid | ptr==query_last).
  - q_ready = SERVE & !clear_start & (!w_valid | ptr==write_last).
  - If only one valid is high, that port gets ready.
  - Ready may depend combinationally on the other port's valid.
  - The pointer updates on every accepted transfer.
- **Accepted write.** Next edge: mem_address={w_to,w_from}, mem_write_data=w_data, mem_write_enable=1 for one cycle.
- **Accepted query.** Next edge: mem_address={q_to,q_from}, mem_write_enable=0. The query is tagged in a 2-stage valid pipeline.
- **Out-of-range index.** Applies when from or to ≥ MAX_NODES.
  - A write is accepted and dropped: no mem_write_enable.
  - A query is accepted and returns INF_VALUE with normal latency.
- **clear_start in SERVE.** No transfer is accepted that cycle. The next state is CLEAR.
- **CLEAR.**
  - Counters `to` and `from` start at 0, with `from` as the inner loop.
  - Each cycle issues one write of INF_VALUE to {to,from}.
  - The sweep covers MAX_NODES² writes.
  - clear_done pulses alongside the final write.
  - The state then returns to SERVE.
  - Both readys are 0 and busy is 1 in CLEAR.
- clear_start during CLEAR is ignored.
- Queries accepted before CLEAR still complete and return pre-clear data. Clear writes never overtake an in-flight read.
- Reset mid-clear: abort immediately to SERVE. Partially cleared contents are undefined.

## Timing
- Query latency is 2 cycles:
  - accept at edge T
  - address registered at T+1
  - RAM data registered at T+2
  - q_resp_valid=1, with q_resp_data = mem_edge_value (or INF_VALUE), during the cycle after edge T+2
- Back-to-back queries give one response per cycle, in order.
- Write visibility: a query accepted in the cycle after a write to the same address returns the new value.
- Clear duration is MAX_NODES² cycles from the first clear write.
  - With MAX_NODES=32: 1024 write cycles.
  - busy rises at the edge after clear_start.
  - busy falls on the edge after the last write.
- q_resp_valid is never backpressured; the consumer must accept it.

## Test plan
- **Reset then clear.** Pulse clear_start, then query (3,7).
  - Expect busy for 1024 cycles and clear_done exactly once.
  - The query returns 32'h7F800000, 2 cycles after acceptance.
- **Write then query.** Write (from=2,to=5,data=32'h40490FDB) then query (2,5) in the next cycle.
  - Expect mem_address=10'b00101_00010 and mem_write_enable for 1 cycle.
  - The response is 32'h40490FDB.
- **Contention.** Hold w_valid and q_valid high for 6 cycles.
  - Grants alternate W,Q,W,Q,W,Q.
  - Exactly one ready per cycle; 3 responses in order.
- **Streaming queries.** Issue 8 back-to-back queries to preloaded distinct edges.
  - Expect 8 consecutive q_resp_valid cycles with matching data.
- **Boundary.** Run with MAX_NODES=20: write to (21,0) then query (21,0).
  - No RAM write occurs; the query returns INF_VALUE.
- **Abort and collision.** clear_start in the same cycle as w_valid: no accept that cycle, and CLEAR is entered. Assert reset at clear cycle 100: outputs go to 0 immediately, and the next cycle is in SERVE with w_ready=1 given w_valid.
